fir_mc_tdm: RTL
===============

// Module: fir_mc_tdm
// PURPOSE
//  Multi-channel, time-multiplexed FIR filter: one shared MAC evaluates N_TAPS taps
//  for each input sample. Each of N_CH channels has its own delay line.
//  Coefficients are programmable at runtime. Output is rounded, scaled and saturated.
//  Handshakes are valid/ready on both sides; the block sits between the sample
//  source and the downstream DSP chain.
// PARAMETERS
//  SAMPLE_WIDTH  16  signed input sample width
//  COEFF_WIDTH   16  signed coefficient width
//  N_TAPS        32  taps per channel (>=2); shared by all channels
//  N_CH          4   channel count (>=1)
//  OUT_WIDTH     16  signed output width after scaling
//  SHIFT         15  arithmetic right shift applied to the accumulator (0..ACC_W-1)
// PORTS
//  clk           in   1                  clock
//  rst_n         in   1                  reset: asynchronous, active-low
//  clr           in   1                  sync clear: zero all delay lines, abort current sample
//  coef_wr_en    in   1                  coefficient write strobe
//  coef_wr_addr  in   clog2(N_TAPS)      tap index k
//  coef_wr_data  in   COEFF_WIDTH        signed h[k]
//  coef_wr_err   out  1                  1-cycle pulse: write rejected because the block was busy
//  s_valid       in   1                  input sample valid
//  s_ready       out  1                  block can accept a sample
//  s_data        in   SAMPLE_WIDTH       signed sample
//  s_ch          in   clog2(N_CH)        channel of s_data
//  m_valid       out  1                  output valid
//  m_ready       in   1                  downstream ready
//  m_data        out  OUT_WIDTH          signed filtered result
//  m_ch          out  clog2(N_CH)        channel of m_data
//  m_sat         out  1                  1 = m_data was saturated
// BEHAVIOUR
//  - Reset: all outputs 0 except s_ready. FSM=IDLE, so s_ready=1 once rst_n is released.
//    Coefficients and delay lines are reset to 0.
//  - Function: y_c[n] = sum_{k=0..N_TAPS-1} h[k]*x_c[n-k]. The accepted sample is x_c[n].
//  - FSM states:
//    IDLE: s_ready=1. On s_valid&s_ready, shift line[s_ch] (x[n] enters index 0),
//      latch the channel, clear acc, then go to MAC.
//    MAC: one product per cycle, k=0..N_TAPS-1. After k=N_TAPS-1, go to OUT.
//    OUT: m_valid=1; m_data, m_ch and m_sat are held stable. On m_ready, go to IDLE.
//  - Timing: accept at cycle T; MAC runs T+1..T+N_TAPS; m_valid rises at T+N_TAPS+1.
//    Throughput is 1 sample per N_TAPS+2 cycles with m_ready held at 1.
//  - Arithmetic: ACC_W = SAMPLE_WIDTH+COEFF_WIDTH+clog2(N_TAPS). Full-precision signed
//    accumulate, no intermediate overflow.
//  - Round: r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (round half up).
//    Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; m_sat=1 when clipped.
//  - Coefficient writes: honoured only in IDLE, taking effect next cycle.
//    A write in MAC or OUT is dropped and coef_wr_err pulses.
//    A write in the same cycle as an accepted sample is honoured; the new h applies to that sample.
//  - clr: highest priority after reset. Zeroes every delay line, drops any in-flight result
//    (m_valid falls next cycle), FSM goes to IDLE. Coefficients are kept.
//    clr in the same cycle as s_valid: the sample is not accepted.
//  - An out-of-range s_ch (>=N_CH) is accepted and discarded: no line update, no output.
//  - rst_n asserted mid-MAC or mid-OUT: outputs clear immediately (async). No output is produced.
// TESTING
//  1 Impulse, h[k]=k+1, SHIFT=0, N_TAPS=32: ch0 gets 1 then 0s -> m_data=1,2,...,32,0; m_ch=0.
//  2 Isolation: ch1 impulse 5, ch2 all-zero -> ch1 outputs 5*h[k]; ch2 outputs stay 0.
//  3 Saturation: all h=0x7FFF, x=0x7FFF, SHIFT=15 -> m_data=0x7FFF, m_sat=1.
//    With x=0x8000 -> m_data=0x8000, m_sat=1.
//  4 Rounding, SHIFT=1: acc=3 -> 2; acc=-3 -> -1; acc=2 -> 1 with m_sat=0.
//  5 Backpressure: hold m_ready=0 for 10 cycles -> m_valid and m_data stable, s_ready=0.
//    Release -> s_ready=1 the next cycle.
//  6 coef_wr during MAC -> coef_wr_err pulse, h unchanged. clr mid-MAC -> no output;
//    the next impulse response shows no residue from earlier samples.

Source files
------------

// File: rtl/fir_mc_tdm_if.sv
// fir_mc_tdm_if: sample/result handshakes, coefficient write port and clear for fir_mc_tdm
interface fir_mc_tdm_if #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int COEFF_WIDTH  = 16,
   parameter int N_TAPS       = 32,
   parameter int N_CH         = 4,
   parameter int OUT_WIDTH    = 16
);
   localparam int KW  = $clog2(N_TAPS);
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
   logic                    clr;
   logic                    coef_wr_en;
   logic [KW-1:0]           coef_wr_addr;
   logic [COEFF_WIDTH-1:0]  coef_wr_data;
   logic                    coef_wr_err;
   logic                    s_valid;
   logic                    s_ready;
   logic [SAMPLE_WIDTH-1:0] s_data;
   logic [CHW-1:0]          s_ch;
   logic                    m_valid;
   logic                    m_ready;
   logic [OUT_WIDTH-1:0]    m_data;
   logic [CHW-1:0]          m_ch;
   logic                    m_sat;
   modport master (
      output clr, coef_wr_en, coef_wr_addr, coef_wr_data, s_valid, s_data, s_ch, m_ready,
      input  coef_wr_err, s_ready, m_valid, m_data, m_ch, m_sat
   );
   modport slave (
      input  clr, coef_wr_en, coef_wr_addr, coef_wr_data, s_valid, s_data, s_ch, m_ready,
      output coef_wr_err, s_ready, m_valid, m_data, m_ch, m_sat
   );
endinterface

// File: rtl/fir_mc_tdm.sv
// fir_mc_tdm: multi-channel FIR sharing one MAC, with rounding, scaling and saturation
module fir_mc_tdm #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int COEFF_WIDTH  = 16,
   parameter int N_TAPS       = 32,
   parameter int N_CH         = 4,
   parameter int OUT_WIDTH    = 16,
   parameter int SHIFT        = 15
) (
   input logic        clk,
   input logic        rst_n,
   fir_mc_tdm_if.slave bus
);
   localparam int KW    = $clog2(N_TAPS);
   localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PW    = SAMPLE_WIDTH + COEFF_WIDTH;
   localparam int ACC_W = PW + KW;
   localparam logic [ACC_W:0] ONE = 1;
   localparam logic [ACC_W:0] RND = (ONE << SHIFT) >> 1;
   localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_W:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                                         state_q, state_d;
   logic [N_CH-1:0][N_TAPS-1:0][SAMPLE_WIDTH-1:0]  line_q, line_d;
   logic [N_TAPS-1:0][COEFF_WIDTH-1:0]             coef_q, coef_d;
   logic signed [ACC_W-1:0]                        acc_q, acc_d;
   logic [KW-1:0]                                  k_q, k_d;
   logic [CHW-1:0]                                 ch_q, ch_d;
   logic                                           err_q, err_d;
   logic                                           rdy, accept, ch_ok, sat_hi, sat_lo;
   logic signed [PW-1:0]                           prod;
   logic signed [ACC_W:0]                          rnd, shd;

   assign rdy    = (state_q == IDLE) && !bus.clr;
   assign accept = bus.s_valid && rdy;
   assign ch_ok  = {1'b0, bus.s_ch} < (CHW+1)'(N_CH);
   assign prod   = $signed(coef_q[k_q]) * $signed(line_q[ch_q][k_q]);
   assign rnd    = $signed({acc_q[ACC_W-1], acc_q}) + $signed(RND);
   assign shd    = rnd >>> SHIFT;
   assign sat_hi = shd > OMAX;
   assign sat_lo = shd < OMIN;

   assign bus.s_ready     = rdy;
   assign bus.m_valid     = state_q == OUT;
   assign bus.m_ch        = ch_q;
   assign bus.m_sat       = sat_hi || sat_lo;
   assign bus.m_data      = sat_hi ? OMAX[OUT_WIDTH-1:0] : (sat_lo ? OMIN[OUT_WIDTH-1:0] : shd[OUT_WIDTH-1:0]);
   assign bus.coef_wr_err = err_q;

   // next state: accept/shift in IDLE, one tap per cycle in MAC, hold result in OUT; clr overrides
   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      coef_d  = coef_q;
      acc_d   = acc_q;
      k_d     = k_q;
      ch_d    = ch_q;
      err_d   = bus.coef_wr_en && (state_q != IDLE);
      if (bus.coef_wr_en && state_q == IDLE) coef_d[bus.coef_wr_addr] = bus.coef_wr_data;
      case (state_q)
         IDLE: if (accept && ch_ok) begin
            line_d[bus.s_ch] = {line_q[bus.s_ch][N_TAPS-2:0], bus.s_data};
            ch_d    = bus.s_ch;
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
         end
         MAC: begin
            acc_d   = acc_q + ACC_W'(prod);
            k_d     = k_q + 1'b1;
            state_d = (k_q == KW'(N_TAPS - 1)) ? OUT : MAC;
         end
         OUT:     state_d = bus.m_ready ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
      if (bus.clr) begin
         line_d  = '0;
         acc_d   = '0;
         state_d = IDLE;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // delay lines, coefficients, accumulator and bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
         coef_q <= '0;
         acc_q  <= '0;
         k_q    <= '0;
         ch_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         line_q <= line_d;
         coef_q <= coef_d;
         acc_q  <= acc_d;
         k_q    <= k_d;
         ch_q   <= ch_d;
         err_q  <= err_d;
      end
   end
endmodule
